// File: rtl/iomem_uart_master_if.sv
// Byte-stream and iomem initiator signals of the UART debug bridge.
// The master modport is the bridge's view; slave is the host/responder side.
interface iomem_uart_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, m_ready, m_rdata,
    output rx_ready, tx_data, tx_valid, m_valid, m_wstrb, m_addr, m_wdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, m_ready, m_rdata,
    input  rx_ready, tx_data, tx_valid, m_valid, m_wstrb, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/iomem_uart_master.sv
// UART-to-iomem debug bridge: decodes 'W'/'R' byte commands, runs one iomem
// transfer with a wait timeout, and streams status or read data back.
module iomem_uart_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52
) (
  input logic                 clk,
  input logic                 resetn,
  iomem_uart_master_if.master bus
);
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h45;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      state_q,    state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  cnt_q,      cnt_d;
  logic [15:0] wait_q,     wait_d;
  logic        m_valid_q,  m_valid_d;
  logic [3:0]  m_wstrb_q,  m_wstrb_d;
  logic [31:0] m_addr_q,   m_addr_d;
  logic [31:0] m_wdata_q,  m_wdata_d;
  logic [31:0] shift_q,    shift_d;
  logic [1:0]  left_q,     left_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q,  tx_data_d;
  logic        rx_ready;
  logic        rx_fire;
  logic        start_bus;

  assign rx_ready = resetn && (state_q inside {S_IDLE, S_ADDR, S_DATA});
  assign rx_fire  = bus.rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    m_valid_d  = m_valid_q;
    m_wstrb_d  = m_wstrb_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    shift_d    = shift_q;
    left_d     = left_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    start_bus  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
          state_d    = S_ADDR;
          is_write_d = (bus.rx_data == CMD_WRITE);
          cnt_d      = '0;
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          m_addr_d = {m_addr_q[23:0], bus.rx_data};
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_write_q) state_d = S_DATA;
            else            start_bus = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          m_wdata_d = {m_wdata_q[23:0], bus.rx_data};
          cnt_d     = cnt_q + 2'd1;
          start_bus = (cnt_q == 2'd3);
        end
      end
      S_BUS: begin
        // Completion wins over a timeout landing on the same edge.
        if (bus.m_ready) begin
          m_valid_d  = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (is_write_q) begin
            tx_data_d = RSP_OK;
            left_d    = '0;
          end else begin
            tx_data_d = bus.m_rdata[31:24];
            shift_d   = {bus.m_rdata[23:0], 8'h00};
            left_d    = 2'd3;
          end
        end else if (wait_q == WAIT_LAST) begin
          m_valid_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ERR;
          left_d     = '0;
          state_d    = S_RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RESP: begin
        if (bus.tx_ready) begin
          if (left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = shift_q[31:24];
            shift_d   = {shift_q[23:0], 8'h00};
            left_d    = left_q - 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_bus) begin
      state_d   = S_BUS;
      m_valid_d = 1'b1;
      m_wstrb_d = is_write_q ? 4'hF : 4'h0;
      wait_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      wait_q     <= '0;
      m_valid_q  <= 1'b0;
      m_wstrb_q  <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      shift_q    <= '0;
      left_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      m_valid_q  <= m_valid_d;
      m_wstrb_q  <= m_wstrb_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      shift_q    <= shift_d;
      left_q     <= left_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_wstrb  = m_wstrb_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule
